pipe_stage_hs: RTL and testbench

//   Parametrised pipeline-stage register for the RISC-V core, replacing the

---
 rtl/pipe_stage_hs.sv | 125 ++++++++++++
 tb/tb_pipe_stage_hs.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_hs.sv
// Pipeline-stage register with valid/ready handshake, optional 2-entry skid
// buffer, global stall/flush, control-field zeroing and a saturating bubble
// counter. Sits between two core stages (e.g. EXE->MEM, MEM->WB).
module pipe_stage_hs #(
  parameter int unsigned DATA_W = 96,
  parameter int unsigned CTRL_W = 12,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              stall,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StFull  = 2'd1,
    StSkid  = 2'd2
  } state_e;

  state_e              state_q;
  logic [CTRL_W-1:0]   main_ctrl_q;
  logic [DATA_W-1:0]   main_data_q;
  logic [CTRL_W-1:0]   skid_ctrl_q;
  logic [DATA_W-1:0]   skid_data_q;
  logic [CNT_W-1:0]    bubble_q;

  logic acc;
  logic deq;

  // Handshake decode; with SKID=1 in_ready depends only on registered state.
  always_comb begin
    if (SKID != 0) begin
      in_ready = (state_q != StSkid) && !stall;
    end else begin
      in_ready = ((state_q == StEmpty) || out_ready) && !stall;
    end
    out_valid = (state_q != StEmpty);
    acc       = in_valid && in_ready;
    deq       = out_valid && out_ready && !stall;
  end

  // Head entry drives the outputs; gated so an empty stage shows all zeros.
  always_comb begin
    out_ctrl   = out_valid ? main_ctrl_q : '0;
    out_data   = out_valid ? main_data_q : '0;
    occupancy  = state_q;
    bubble_cnt = bubble_q;
  end

  // Stage FSM, entry registers and bubble counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      bubble_q    <= '0;
    end else begin
      // Counts empty-output edges regardless of stall/flush; only reset clears it.
      if (!out_valid && (bubble_q != '1)) begin
        bubble_q <= bubble_q + 1'b1;
      end

      if (flush) begin
        state_q     <= StEmpty;
        main_ctrl_q <= '0;
        main_data_q <= '0;
        skid_ctrl_q <= '0;
        skid_data_q <= '0;
      end else if (!stall) begin
        case (state_q)
          StEmpty: begin
            if (acc) begin
              main_ctrl_q <= in_ctrl;
              main_data_q <= in_data;
              state_q     <= StFull;
            end
          end
          StFull: begin
            if (acc && deq) begin
              main_ctrl_q <= in_ctrl;
              main_data_q <= in_data;
            end else if (acc && (SKID != 0)) begin
              // Downstream blocked: park the new entry behind main.
              skid_ctrl_q <= in_ctrl;
              skid_data_q <= in_data;
              state_q     <= StSkid;
            end else if (deq) begin
              main_ctrl_q <= '0;
              main_data_q <= '0;
              state_q     <= StEmpty;
            end
          end
          StSkid: begin
            if (deq) begin
              main_ctrl_q <= skid_ctrl_q;
              main_data_q <= skid_data_q;
              skid_ctrl_q <= '0;
              skid_data_q <= '0;
              state_q     <= StFull;
            end
          end
          default: begin
            state_q <= StEmpty;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: one SKID=1 and one SKID=0 instance share stimulus.
// Each is checked every cycle against a queue-based model, plus a vector table
// and hand-written sequences for stall, flush, async reset and saturation.
module tb_pipe_stage_hs;

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;
  localparam int unsigned NW = 4;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          stall;
  logic          in_valid;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_ready;

  logic          o1_rdy, o1_valid;
  logic [CW-1:0] o1_ctrl;
  logic [DW-1:0] o1_data;
  logic [1:0]    o1_occ;
  logic [NW-1:0] o1_bub;

  logic          o0_rdy, o0_valid;
  logic [CW-1:0] o0_ctrl;
  logic [DW-1:0] o0_data;
  logic [1:0]    o0_occ;
  logic [NW-1:0] o0_bub;

  pipe_stage_hs #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(NW)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_ready(o1_rdy), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(o1_valid), .out_ready(out_ready), .out_ctrl(o1_ctrl), .out_data(o1_data),
    .occupancy(o1_occ), .bubble_cnt(o1_bub)
  );

  pipe_stage_hs #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(NW)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_ready(o0_rdy), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(o0_valid), .out_ready(out_ready), .out_ctrl(o0_ctrl), .out_data(o0_data),
    .occupancy(o0_occ), .bubble_cnt(o0_bub)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: a FIFO of {ctrl,data} per instance, capacity 2 or 1.
  logic [CW+DW-1:0] mq1[$];
  logic [CW+DW-1:0] mq0[$];
  int b1 = 0;
  int b0 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic check_models();
    int s1;
    int s0;
    logic [CW+DW-1:0] h1;
    logic [CW+DW-1:0] h0;
    s1 = mq1.size();
    s0 = mq0.size();
    h1 = (s1 > 0) ? mq1[0] : '0;
    h0 = (s0 > 0) ? mq0[0] : '0;
    chk("s1_valid", 32'(o1_valid), 32'(s1 > 0));
    chk("s1_data",  32'(o1_data),  32'(h1[DW-1:0]));
    chk("s1_ctrl",  32'(o1_ctrl),  32'(h1[CW+DW-1:DW]));
    chk("s1_occ",   32'(o1_occ),   32'(s1));
    chk("s1_bub",   32'(o1_bub),   32'(b1));
    chk("s1_rdy",   32'(o1_rdy),   32'(!stall && (s1 < 2)));
    chk("s0_valid", 32'(o0_valid), 32'(s0 > 0));
    chk("s0_data",  32'(o0_data),  32'(h0[DW-1:0]));
    chk("s0_ctrl",  32'(o0_ctrl),  32'(h0[CW+DW-1:DW]));
    chk("s0_occ",   32'(o0_occ),   32'(s0));
    chk("s0_bub",   32'(o0_bub),   32'(b0));
    chk("s0_rdy",   32'(o0_rdy),   32'(!stall && ((s0 == 0) || out_ready)));
  endtask

  task automatic update_models(input bit iv, input bit ord, input bit st, input bit fl,
                               input logic [CW+DW-1:0] e);
    bit r1;
    bit r0;
    bit d1;
    bit d0;
    r1 = !st && (mq1.size() < 2);
    r0 = !st && ((mq0.size() == 0) || ord);
    d1 = (mq1.size() > 0) && ord && !st;
    d0 = (mq0.size() > 0) && ord && !st;
    if ((mq1.size() == 0) && (b1 < 15)) b1++;
    if ((mq0.size() == 0) && (b0 < 15)) b0++;
    if (fl) begin
      mq1.delete();
      mq0.delete();
    end else begin
      if (d1) void'(mq1.pop_front());
      if (iv && r1) mq1.push_back(e);
      if (d0) void'(mq0.pop_front());
      if (iv && r0) mq0.push_back(e);
    end
  endtask

  // One clock: drive at negedge, check pre-edge, advance model, return at negedge.
  task automatic step(input bit iv, input bit ord, input bit st, input bit fl,
                      input logic [DW-1:0] d);
    in_valid  = iv;
    out_ready = ord;
    stall     = st;
    flush     = fl;
    in_data   = d;
    in_ctrl   = d[CW-1:0];
    #1;
    check_models();
    @(posedge clk);
    update_models(iv, ord, st, fl, {d[CW-1:0], d});
    @(negedge clk);
  endtask

  typedef struct {
    bit          iv;
    bit          ord;
    logic [15:0] d;
    bit          e_v;
    logic [15:0] e_d;
    int          e_occ;
    bit          e_rdy;
  } vec_t;

  vec_t tbl[9];

  initial begin
    // Streaming 1,2,3 then drain; then back-pressure A=0x11, B=0x22 (0x33 refused).
    tbl[0] = '{1'b1, 1'b1, 16'h0001, 1'b1, 16'h0001, 1, 1'b1};
    tbl[1] = '{1'b1, 1'b1, 16'h0002, 1'b1, 16'h0002, 1, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 16'h0003, 1'b1, 16'h0003, 1, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 0, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 16'h0011, 1'b1, 16'h0011, 1, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 16'h0022, 1'b1, 16'h0011, 2, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 16'h0033, 1'b1, 16'h0011, 2, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 16'h0000, 1'b1, 16'h0022, 1, 1'b1};
    tbl[8] = '{1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 0, 1'b1};

    rst_n = 1'b0; flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
    in_ctrl = '0; in_data = '0; out_ready = 1'b0;
    #1;
    chk("rst_valid", 32'(o1_valid), 32'd0);
    chk("rst_occ",   32'(o1_occ),   32'd0);
    chk("rst_bub",   32'(o1_bub),   32'd0);
    chk("rst_rdy",   32'(o1_rdy),   32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].iv, tbl[i].ord, 1'b0, 1'b0, tbl[i].d);
      chk($sformatf("tbl%0d_valid", i), 32'(o1_valid), 32'(tbl[i].e_v));
      chk($sformatf("tbl%0d_data", i),  32'(o1_data),  32'(tbl[i].e_d));
      chk($sformatf("tbl%0d_ctrl", i),  32'(o1_ctrl),  32'(tbl[i].e_d[3:0]));
      chk($sformatf("tbl%0d_occ", i),   32'(o1_occ),   32'(tbl[i].e_occ));
      chk($sformatf("tbl%0d_rdy", i),   32'(o1_rdy),   32'(tbl[i].e_rdy));
    end

    // Stall holds a FULL stage for three cycles, then it drains.
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0007);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0008);
      chk("stall_data", 32'(o1_data), 32'h7);
      chk("stall_occ",  32'(o1_occ),  32'd1);
      chk("stall_rdy",  32'(o1_rdy),  32'd0);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    chk("resume_valid", 32'(o1_valid), 32'd0);

    // Flush in SKID state while offering 0x55.
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0011);
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0022);
    chk("pre_flush_occ", 32'(o1_occ), 32'd2);
    step(1'b1, 1'b1, 1'b0, 1'b1, 16'h0055);
    chk("flush_valid", 32'(o1_valid), 32'd0);
    chk("flush_ctrl",  32'(o1_ctrl),  32'd0);
    chk("flush_data",  32'(o1_data),  32'd0);
    chk("flush_occ",   32'(o1_occ),   32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    chk("post_flush_valid", 32'(o1_valid), 32'd0);

    // Asynchronous reset mid-cycle while in SKID state.
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0011);
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0022);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_valid", 32'(o1_valid), 32'd0);
    chk("areset_occ",   32'(o1_occ),   32'd0);
    chk("areset_bub",   32'(o1_bub),   32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stall = 1'b0;
    mq1.delete(); mq0.delete(); b1 = 0; b0 = 0;
    #1;
    chk("areset_rdy1", 32'(o1_rdy), 32'd1);
    chk("areset_rdy0", 32'(o0_rdy), 32'd1);

    // Bubble counter saturates at 15 with a 4-bit counter.
    for (int k = 0; k < 20; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    chk("sat_bub1", 32'(o1_bub), 32'd15);
    chk("sat_bub0", 32'(o0_bub), 32'd15);

    // SKID=0: in_ready follows out_ready combinationally when FULL.
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0011);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("comb_rdy_lo", 32'(o0_rdy), 32'd0);
    out_ready = 1'b1;
    #1;
    chk("comb_rdy_hi", 32'(o0_rdy), 32'd1);

    // Randomised traffic against the model.
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0),
           16'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
